// File: rtl/window_gen_3x3_pkg.sv
// window_gen_3x3_pkg
//   Shared types for the two-lane 3x3 window generator and the smoothing
//   filter it feeds.
//   pix_pair_t : two horizontally adjacent pixels, index = lane (0 = left)
//   window_t   : two 3x3 windows, image[j][lane], j = row*3+col,
//                row 0 = oldest, col 0 = leftmost
//   win_state_t: line-buffer fill state of the generator
package window_gen_3x3_pkg;

  localparam int PIX_W = 8;
  localparam int LANES = 2;
  localparam int WIN   = 9;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef pix_t [LANES-1:0]  pix_pair_t;
  typedef pix_pair_t [WIN-1:0] window_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// line_buffer
//   One image row of pixel pairs. One read port with a registered output and
//   one write port. A read and a write in the same cycle return the old word.
//   Ports:
//     clk         rising-edge clock
//     rd_en       update rdata from mem[raddr]
//     raddr/rdata read address / registered read data
//     we          write wdata to mem[waddr]
//     waddr/wdata write address / data
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int DW    = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (rd_en) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Builds two overlapping 3x3 pixel windows per accepted pixel pair from a
//   two-pixel-per-clock raster stream, using two row line buffers and a
//   two-pair shift register per window row.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     pix_in          pixel pair, lane 0 = even (left) column
//     in_valid, sof   pair valid / first pair of a frame
//     stall           downstream hold; freezes all state and outputs
//     in_ready        = ~stall
//     image           two windows, image[row*3+col][lane]
//     out_valid       image holds a fresh window pair
//   Optional (macro WINDOW_FRAME_STATS_EN):
//     frame_done      one pulse with the last window of a frame
//     win_count       windows emitted since reset (two per pair), saturating
//
//   state | meaning
//   FILL  | rows 0..1 of a frame: line buffers refilling, no windows
//   RUN   | rows 2..IMG_H-1: windows emitted for col >= 1
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic      clk,
  input  logic      reset,
  input  pix_pair_t pix_in,
  input  logic      in_valid,
  input  logic      sof,
  input  logic      stall,
  output logic      in_ready,
  output window_t   image,
  output logic      out_valid
`ifdef WINDOW_FRAME_STATS_EN
  ,
  output logic        frame_done,
  output logic [31:0] win_count
`endif
);

  localparam int PAIRS = IMG_W / 2;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  win_state_t state, state_nxt;
  logic [COL_W-1:0] col, col_nxt, wr_col;
  logic [ROW_W-1:0] row, row_nxt;
  logic accept, col_last, row_last, win_fire;
  pix_pair_t l1_rd, l2_rd;
  pix_pair_t prev_q   [3];
  pix_pair_t cur_pair [3];
  window_t   win_nxt;

  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;
  assign col_last = (col == COL_W'(PAIRS - 1));
  assign row_last = (row == ROW_W'(IMG_H - 1));

  // A sof pair is column 0 of a fresh frame, so the next pair is column 1.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (reset) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (accept) begin
      if (sof) begin
        col_nxt = COL_W'(1);
        row_nxt = '0;
      end else if (col_last) begin
        col_nxt = '0;
        row_nxt = row_last ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    col <= col_nxt;
    row <= row_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (sof) begin
        state_nxt = FILL;
      end else if (col_last) begin
        if (state == FILL && row == ROW_W'(1)) state_nxt = RUN;
        else if (state == RUN && row_last)     state_nxt = FILL;
      end
    end
  end

  // col != 0 keeps a window from straddling the previous row's tail.
  always_comb begin
    win_fire = accept & ~sof & (state == RUN) & (col != '0);
  end

  // The read side prefetches the column the next accepted pair will use, so
  // rows r-1/r-2 for that column are already registered when it arrives.
  assign wr_col = sof ? '0 : col;

  line_buffer #(.DEPTH(PAIRS), .DW(2 * PIX_W), .AW(COL_W)) u_lb_r1 (
    .clk   (clk),
    .rd_en (~stall | reset),
    .raddr (col_nxt),
    .rdata (l1_rd),
    .we    (accept),
    .waddr (wr_col),
    .wdata (pix_in)
  );

  line_buffer #(.DEPTH(PAIRS), .DW(2 * PIX_W), .AW(COL_W)) u_lb_r2 (
    .clk   (clk),
    .rd_en (~stall | reset),
    .raddr (col_nxt),
    .rdata (l2_rd),
    .we    (accept),
    .waddr (wr_col),
    .wdata (l1_rd)
  );

  always_comb begin
    cur_pair[0] = l2_rd;
    cur_pair[1] = l1_rd;
    cur_pair[2] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) prev_q[r] <= cur_pair[r];
    end
  end

  // Each window row sees a 4-pixel strip: previous pair then current pair.
  // Lane l takes strip positions c+l for c = 0..2.
  always_comb begin
    int pos;
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        for (int l = 0; l < LANES; l++) begin
          pos = c + l;
          if (pos < 2) win_nxt[r*3+c][l] = prev_q[r][pos[0]];
          else         win_nxt[r*3+c][l] = cur_pair[r][pos[0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      image     <= '0;
    end else if (!stall) begin
      out_valid <= win_fire;
      if (win_fire) image <= win_nxt;
    end
  end

`ifdef WINDOW_FRAME_STATS_EN
  logic frame_end;
  assign frame_end = win_fire & col_last & row_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      win_count  <= '0;
    end else if (!stall) begin
      frame_done <= frame_end;
      if (win_fire)
        win_count <= (win_count >= 32'hFFFF_FFFE) ? '1 : win_count + 32'd2;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;
  import window_gen_3x3_pkg::*;

  localparam int W = 6;
  localparam int H = 4;
  localparam int P = W / 2;

  logic      clk = 1'b0;
  logic      reset, in_valid, sof, stall, in_ready, out_valid;
  pix_pair_t pix_in;
  window_t   image;
`ifdef WINDOW_FRAME_STATS_EN
  logic        frame_done;
  logic [31:0] win_count;
  logic        exp_fd;
  logic [31:0] exp_wc;
  int          n_fd;
`endif

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .in_valid  (in_valid),
    .sof       (sof),
    .stall     (stall),
    .in_ready  (in_ready),
    .image     (image),
    .out_valid (out_valid)
`ifdef WINDOW_FRAME_STATS_EN
    ,
    .frame_done(frame_done),
    .win_count (win_count)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: frame stored as a plain pixel array
  int         m_row, m_col;
  logic [7:0] fr [H][W];
  logic       exp_valid;
  window_t    exp_img;
  window_t    q_cap [$];
  window_t    q_ref [$];

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic check_win(input string tag, input window_t got, input window_t exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input longint got, input longint exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input logic v, input logic s, input logic st, input logic rst,
                       input pix_pair_t p);
    bit fire, lastp;
    if (rst) begin
      m_row = 0; m_col = 0; exp_valid = 1'b0; exp_img = '0;
`ifdef WINDOW_FRAME_STATS_EN
      exp_fd = 1'b0; exp_wc = '0;
`endif
    end else if (!st) begin
      fire = 0; lastp = 0;
      if (v) begin
        if (s) begin m_row = 0; m_col = 0; end
        fr[m_row][2*m_col]   = p[0];
        fr[m_row][2*m_col+1] = p[1];
        fire  = (m_row >= 2) && (m_col >= 1);
        lastp = (m_row == H-1) && (m_col == P-1);
        if (fire)
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              for (int l = 0; l < 2; l++)
                exp_img[r*3+c][l] = fr[m_row-2+r][2*m_col-2+c+l];
        m_col++;
        if (m_col == P) begin m_col = 0; m_row = (m_row + 1) % H; end
      end
      exp_valid = fire;
`ifdef WINDOW_FRAME_STATS_EN
      exp_fd = fire && lastp;
      if (fire) exp_wc = (exp_wc >= 32'hFFFF_FFFE) ? 32'hFFFF_FFFF : exp_wc + 32'd2;
`endif
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic st, input logic rst,
                     input pix_pair_t p);
    in_valid = v; sof = s; stall = st; reset = rst; pix_in = p;
    #1;
    check_bit("in_ready", in_ready, ~st);
    @(posedge clk);
    #1;
    model(v, s, st, rst, p);
    check_bit("out_valid", out_valid, exp_valid);
    check_win("image", image, exp_img);
`ifdef WINDOW_FRAME_STATS_EN
    check_bit("frame_done", frame_done, exp_fd);
    check_int("win_count", win_count, exp_wc);
    if (frame_done && !st && !rst) n_fd++;
`endif
    if (out_valid && !st && !rst) q_cap.push_back(image);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, pix_pair_t'(16'($urandom)));
  endtask

  // pixel = base + 10*row + x; first npairs pairs of the frame
  task automatic send_ramp(input int base, input bit gaps, input int stall_at, input int npairs);
    for (int k = 0; k < npairs; k++) begin
      int r, c;
      pix_pair_t p;
      r = k / P;
      c = k % P;
      p[0] = 8'(base + 10*r + 2*c);
      p[1] = 8'(base + 10*r + 2*c + 1);
      if (gaps) idle($urandom_range(1, 4));
      if (k == stall_at) repeat (3) cyc(1'b1, k == 0, 1'b1, 1'b0, p);
      cyc(1'b1, k == 0, 1'b0, 1'b0, p);
    end
  endtask

  task automatic check_first(input string tag, input int base);
    window_t e;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int l = 0; l < 2; l++)
          e[r*3+c][l] = 8'(base + 10*r + c + l);
    check_int({tag, "_count"}, q_cap.size(), 4);
    if (q_cap.size() > 0) check_win({tag, "_first"}, q_cap[0], e);
  endtask

  task automatic check_same_as_ref(input string tag);
    check_int({tag, "_count"}, q_cap.size(), q_ref.size());
    if (q_cap.size() == q_ref.size())
      for (int i = 0; i < q_ref.size(); i++) check_win(tag, q_cap[i], q_ref[i]);
  endtask

  initial begin
    in_valid = 0; sof = 0; stall = 0; reset = 1; pix_in = '0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check_bit("reset_valid", out_valid, 1'b0);
    check_win("reset_image", image, '0);

    // gapless ramp frame
    q_cap.delete();
    send_ramp(0, 1'b0, -1, P*H);
    idle(2);
    check_first("ramp", 0);
    q_ref = q_cap;

    // idle gaps inside rows
    q_cap.delete();
    send_ramp(0, 1'b1, -1, P*H);
    idle(2);
    check_same_as_ref("gaps");

    // 3-cycle stall while a window is on the output
    q_cap.delete();
    send_ramp(0, 1'b0, 2*P + 2, P*H);
    idle(2);
    check_same_as_ref("stall");

    // sof arriving at row 2 col 1 restarts the frame
    q_cap.delete();
    send_ramp(0, 1'b0, -1, 2*P + 1);
    check_int("pre_sof_windows", q_cap.size(), 0);
    send_ramp(100, 1'b0, -1, P*H);
    idle(2);
    check_first("sof_restart", 100);

    // reset while in RUN with a window on the output
    send_ramp(0, 1'b0, -1, 3*P + 2);
    check_bit("pre_reset_valid", out_valid, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, '0);
    check_bit("post_reset_valid", out_valid, 1'b0);
    q_cap.delete();
    send_ramp(50, 1'b0, -1, P*H);
    idle(2);
    check_first("after_reset", 50);

`ifdef WINDOW_FRAME_STATS_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    n_fd = 0;
    send_ramp(0, 1'b0, -1, P*H);
    idle(2);
    check_int("stats_count1", win_count, 8);
    send_ramp(0, 1'b1, -1, P*H);
    idle(2);
    check_int("stats_count2", win_count, 16);
    check_int("stats_frames", n_fd, 2);
`endif

    // random traffic against the model
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (600) begin
      logic v, s, st, rst;
      v   = ($urandom % 4) != 0;
      st  = ($urandom % 5) == 0;
      s   = ($urandom % 40) == 0;
      rst = ($urandom % 200) == 0;
      cyc(v, s, st, rst, pix_pair_t'(16'($urandom)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
